proc_assume_sequencer: RTL and testbench
========================================

Name: proc_assume_sequencer

Overview:
- Drives the per-lane response chain that procedural concurrent assumptions check: a qualified request on lane i gives ack[i] one cycle later, then the shared done strobe one cycle after that.
- Sits next to the guarded procedural-assertion blocks in the assertion test benches and acts as the design-side obligation generator.
- An FSM tracks the activation condition. Obligations that are already accepted always complete, even if activation drops.
- Saturating statistics count accepted lane-requests.

Parameters:
- NUM_LANES, 2, number of request/ack lanes (1..16)
- CNT_W, 8, width of accepted-request counter

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- act_en  input  1  activation condition; requests are qualified only while high
- lane_mask  input  NUM_LANES  per-lane enable; 0 ignores that lane's requests
- req  input  NUM_LANES  per-lane request
- cnt_clr  input  1  synchronous clear of acc_cnt and cnt_ovf
- ack  output  NUM_LANES  per-lane response, one cycle after accept
- done  output  1  completion strobe, two cycles after accept
- busy  output  1  obligation pipeline non-empty
- state  output  2  FSM state encoding
- acc_cnt  output  CNT_W  saturating count of accepted lane-requests
- cnt_ovf  output  1  sticky saturation flag

Behaviour:
- Reset: ack=0, done=0, busy=0, state=IDLE, acc_cnt=0, cnt_ovf=0. Asserting reset mid-operation discards all in-flight obligations immediately; no ack or done is emitted afterwards.
- Accept: acc[i] = req[i] & lane_mask[i] & act_en, sampled at edge k.
- Timing: ack[i] is registered from acc[i], so it is high and sampled at edge k+1. done is registered from |ack, so it is high and sampled at edge k+2. Latency is fixed with no stalls.
- Overlapping accepts: each lane's ack pulse has the same width as its run of accepts. done stays high continuously across back-to-back obligations.
- Multiple lanes accepted in the same cycle all ack together; done is a single shared strobe.
- busy = |ack | done | (|acc).
- FSM:
  - IDLE=0: act_en=1 goes to ACTIVE; otherwise stay.
  - ACTIVE=1: act_en=0 and busy goes to DRAIN; act_en=0 and !busy goes to IDLE.
  - DRAIN=2: act_en=1 goes to ACTIVE; !busy goes to IDLE. New requests are ignored while act_en=0.
  - Encoding 3 is unreachable and recovers to IDLE.
- act_en dropping at edge k+1 after an accept at k: ack at k+1 and done at k+2 still occur.
- Counter:
  - acc_cnt += popcount(acc), computed at width CNT_W+1.
  - If the sum exceeds 2^CNT_W-1, clamp to all-ones and set cnt_ovf.
  - cnt_clr has priority over a same-cycle accept: count goes to 0, that cycle's accepts are not counted, and cnt_ovf clears.
- lane_mask and act_en are combinational qualifiers only. Changing them never cancels an accepted obligation.

Optional Feature:
- Macro: PROC_SEQ_ASSERT_EN.
- When defined, an always @(posedge clk) block guarded by act_en contains a for loop over lanes. Each iteration holds a procedural concurrent assertion of (req[i] & lane_mask[i]) |=> ack[i] ##1 done, plus an assertion that state never equals 3.
- When not defined, no assertion code is compiled and behaviour is identical.

Decomposition:
- Package proc_seq_pkg holds:
  - enum seq_state_e {IDLE, ACTIVE, DRAIN}
  - constants MAX_LANES=16 and STATE_W=2
  - a popcount function sized by MAX_LANES
- One sub-module, proc_seq_lane: per-lane qualification and ack flop (inputs req, mask, act_en; outputs acc, ack). It is instantiated NUM_LANES times by generate.
- The top level holds done, the FSM and the counter.

Test Plan:
- act_en=1, mask=2'b11, req=2'b01 for one cycle at edge 5 -> ack=2'b01 at edge 6, done=1 at edge 7, acc_cnt=1, state ACTIVE.
- req=2'b11 on three consecutive edges -> ack=2'b11 for 3 cycles, done high for 3 cycles starting one cycle after ack, acc_cnt=6.
- Accept at edge k, act_en dropped at k+1 with req still high -> ack and done complete; state ACTIVE->DRAIN->IDLE; later requests are ignored and acc_cnt stays 1.
- CNT_W=3, seven single-lane accepts then a 2-lane accept -> acc_cnt=7, cnt_ovf=1. cnt_clr together with req=2'b11 -> acc_cnt=0, cnt_ovf=0.
- rst_n asserted one cycle after an accept -> ack, done and busy go to 0 at once; no done pulse after release.
- mask=2'b10, req=2'b11 -> only ack[1] pulses, acc_cnt=1. With PROC_SEQ_ASSERT_EN defined, no assertion failures are reported.

Source files
------------

// File: rtl/proc_seq_pkg.sv
// Shared types, sizing constants and helpers for the procedural-assumption sequencer.
package proc_seq_pkg;

    localparam int MAX_LANES = 16;
    localparam int STATE_W   = 2;
    localparam int POP_W     = $clog2(MAX_LANES) + 1;

    typedef enum logic [STATE_W-1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DRAIN  = 2'd2
    } seq_state_e;

    function automatic logic [POP_W-1:0] popcount(input logic [MAX_LANES-1:0] v);
        logic [POP_W-1:0] n;
        n = '0;
        for (int i = 0; i < MAX_LANES; i++) begin
            n = n + POP_W'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/proc_seq_lane.sv
// One request lane: qualifies the raw request and registers the ack one cycle later.
module proc_seq_lane
    import proc_seq_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic req,
    input  logic mask,
    input  logic act_en,
    output logic acc,
    output logic ack
);

    assign acc = req & mask & act_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack <= 1'b0;
        end else begin
            ack <= acc;
        end
    end

endmodule

// File: rtl/proc_assume_sequencer.sv
// Obligation generator: accept -> ack one cycle later -> shared done one cycle after that.
// Optional build macro PROC_SEQ_ASSERT_EN compiles in procedural concurrent assertions.
module proc_assume_sequencer
    import proc_seq_pkg::*;
#(
    parameter int NUM_LANES = 2,
    parameter int CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 act_en,
    input  logic [NUM_LANES-1:0] lane_mask,
    input  logic [NUM_LANES-1:0] req,
    input  logic                 cnt_clr,
    output logic [NUM_LANES-1:0] ack,
    output logic                 done,
    output logic                 busy,
    output logic [STATE_W-1:0]   state,
    output logic [CNT_W-1:0]     acc_cnt,
    output logic                 cnt_ovf
);

    // Sum is at least CNT_W+1 bits, widened further so a full popcount never wraps.
    localparam int SUM_W = (CNT_W + 1 > POP_W + 1) ? CNT_W + 1 : POP_W + 1;
    localparam logic [SUM_W-1:0] CNT_MAX = {{(SUM_W - CNT_W){1'b0}}, {CNT_W{1'b1}}};

    logic [NUM_LANES-1:0] acc;
    logic [MAX_LANES-1:0] acc_ext;
    logic [POP_W-1:0]     acc_pop;
    logic [SUM_W-1:0]     cnt_sum;
    seq_state_e           state_q;
    seq_state_e           state_d;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        proc_seq_lane u_lane (
            .clk    (clk),
            .rst_n  (rst_n),
            .req    (req[i]),
            .mask   (lane_mask[i]),
            .act_en (act_en),
            .acc    (acc[i]),
            .ack    (ack[i])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done <= 1'b0;
        end else begin
            done <= |ack;
        end
    end

    assign busy  = (|ack) | done | (|acc);
    assign state = state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // State only tracks activation; in-flight acks/done drain regardless of it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (act_en) state_d = ACTIVE;
            end
            ACTIVE: begin
                if (!act_en) state_d = busy ? DRAIN : IDLE;
            end
            DRAIN: begin
                if (act_en)     state_d = ACTIVE;
                else if (!busy) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        acc_ext                = '0;
        acc_ext[NUM_LANES-1:0] = acc;
    end

    assign acc_pop = popcount(acc_ext);
    assign cnt_sum = SUM_W'(acc_cnt) + SUM_W'(acc_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_cnt <= '0;
            cnt_ovf <= 1'b0;
        end else if (cnt_clr) begin
            acc_cnt <= '0;
            cnt_ovf <= 1'b0;
        end else if (cnt_sum > CNT_MAX) begin
            acc_cnt <= '1;
            cnt_ovf <= 1'b1;
        end else begin
            acc_cnt <= cnt_sum[CNT_W-1:0];
        end
    end

`ifdef PROC_SEQ_ASSERT_EN
    always @(posedge clk) begin
        if (act_en) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                assert property (@(posedge clk) disable iff (!rst_n)
                    (req[i] & lane_mask[i]) |=> ack[i] ##1 done);
            end
            assert property (@(posedge clk) disable iff (!rst_n) state != 2'd3);
        end
    end
`else
`endif

endmodule

// File: tb/tb_proc_assume_sequencer.sv
// Table-driven scoreboard bench for proc_assume_sequencer (CNT_W=8 and CNT_W=3 instances).
module tb_proc_assume_sequencer;

    typedef struct {
        logic       act_en;
        logic [1:0] mask;
        logic [1:0] req;
        logic       clr;
        logic [1:0] exp_ack;
        logic       exp_done;
        logic [1:0] exp_state;
        logic [7:0] exp_cnt;
        logic       exp_ovf;
        logic [2:0] exp_cnt3;
        logic       exp_ovf3;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       act_en;
    logic [1:0] lane_mask;
    logic [1:0] req;
    logic       cnt_clr;

    logic [1:0] ack,  ack3;
    logic       done, done3;
    logic       busy, busy3;
    logic [1:0] state, state3;
    logic [7:0] acc_cnt;
    logic [2:0] acc_cnt3;
    logic       cnt_ovf, cnt_ovf3;

    int   vec_count = 0;
    int   err_count = 0;
    vec_t vecs[30];
    vec_t exp_q[$];

    always #5 clk = ~clk;

    proc_assume_sequencer #(.NUM_LANES(2), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .act_en(act_en), .lane_mask(lane_mask),
        .req(req), .cnt_clr(cnt_clr), .ack(ack), .done(done), .busy(busy),
        .state(state), .acc_cnt(acc_cnt), .cnt_ovf(cnt_ovf)
    );

    proc_assume_sequencer #(.NUM_LANES(2), .CNT_W(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .act_en(act_en), .lane_mask(lane_mask),
        .req(req), .cnt_clr(cnt_clr), .ack(ack3), .done(done3), .busy(busy3),
        .state(state3), .acc_cnt(acc_cnt3), .cnt_ovf(cnt_ovf3)
    );

    function automatic vec_t mk(logic a, logic [1:0] m, logic [1:0] r, logic c,
                                logic [1:0] ea, logic ed, logic [1:0] es,
                                logic [7:0] ec, logic eo, logic [2:0] ec3, logic eo3);
        vec_t v;
        v.act_en = a;   v.mask = m;       v.req = r;         v.clr = c;
        v.exp_ack = ea; v.exp_done = ed;  v.exp_state = es;
        v.exp_cnt = ec; v.exp_ovf = eo;   v.exp_cnt3 = ec3;  v.exp_ovf3 = eo3;
        return v;
    endfunction

    task automatic compareField(input string name, input logic [31:0] got, input logic [31:0] exp);
        vec_count++;
        if (got !== exp) begin
            err_count++;
            $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        act_en    = v.act_en;
        lane_mask = v.mask;
        req       = v.req;
        cnt_clr   = v.clr;
        exp_q.push_back(v);
    endtask

    task automatic checkOutput();
        vec_t e;
        logic exp_busy;
        if (exp_q.size() == 0) begin
            compareField("scoreboard_empty", 32'd1, 32'd0);
            return;
        end
        e = exp_q.pop_front();
        exp_busy = (|e.exp_ack) | e.exp_done | (|(e.req & e.mask & {2{e.act_en}}));
        compareField("ack",      32'(ack),      32'(e.exp_ack));
        compareField("done",     32'(done),     32'(e.exp_done));
        compareField("busy",     32'(busy),     32'(exp_busy));
        compareField("state",    32'(state),    32'(e.exp_state));
        compareField("acc_cnt",  32'(acc_cnt),  32'(e.exp_cnt));
        compareField("cnt_ovf",  32'(cnt_ovf),  32'(e.exp_ovf));
        compareField("ack3",     32'(ack3),     32'(e.exp_ack));
        compareField("done3",    32'(done3),    32'(e.exp_done));
        compareField("busy3",    32'(busy3),    32'(exp_busy));
        compareField("state3",   32'(state3),   32'(e.exp_state));
        compareField("acc_cnt3", 32'(acc_cnt3), 32'(e.exp_cnt3));
        compareField("cnt_ovf3", 32'(cnt_ovf3), 32'(e.exp_ovf3));
    endtask

    initial begin
        // Each row: inputs present at an edge, then outputs expected just after it.
        vecs[0]  = mk(1, 2'b11, 2'b00, 0,  2'b00, 0, 2'd1, 8'd0, 0, 3'd0, 0);
        vecs[1]  = mk(1, 2'b11, 2'b01, 0,  2'b01, 0, 2'd1, 8'd1, 0, 3'd1, 0);
        vecs[2]  = mk(1, 2'b11, 2'b00, 0,  2'b00, 1, 2'd1, 8'd1, 0, 3'd1, 0);
        vecs[3]  = mk(1, 2'b11, 2'b00, 0,  2'b00, 0, 2'd1, 8'd1, 0, 3'd1, 0);
        vecs[4]  = mk(1, 2'b11, 2'b11, 0,  2'b11, 0, 2'd1, 8'd3, 0, 3'd3, 0);
        vecs[5]  = mk(1, 2'b11, 2'b11, 0,  2'b11, 1, 2'd1, 8'd5, 0, 3'd5, 0);
        vecs[6]  = mk(1, 2'b11, 2'b11, 0,  2'b11, 1, 2'd1, 8'd7, 0, 3'd7, 0);
        vecs[7]  = mk(1, 2'b11, 2'b00, 0,  2'b00, 1, 2'd1, 8'd7, 0, 3'd7, 0);
        vecs[8]  = mk(1, 2'b11, 2'b00, 0,  2'b00, 0, 2'd1, 8'd7, 0, 3'd7, 0);
        vecs[9]  = mk(1, 2'b11, 2'b00, 1,  2'b00, 0, 2'd1, 8'd0, 0, 3'd0, 0);
        for (int k = 1; k <= 7; k++) begin
            vecs[9+k] = mk(1, 2'b11, 2'b01, 0, 2'b01, (k > 1), 2'd1, 8'(k), 0, 3'(k), 0);
        end
        vecs[17] = mk(1, 2'b11, 2'b11, 0,  2'b11, 1, 2'd1, 8'd9, 0, 3'd7, 1);
        vecs[18] = mk(1, 2'b11, 2'b11, 1,  2'b11, 1, 2'd1, 8'd0, 0, 3'd0, 0);
        vecs[19] = mk(1, 2'b11, 2'b00, 0,  2'b00, 1, 2'd1, 8'd0, 0, 3'd0, 0);
        vecs[20] = mk(1, 2'b11, 2'b00, 0,  2'b00, 0, 2'd1, 8'd0, 0, 3'd0, 0);
        vecs[21] = mk(1, 2'b11, 2'b01, 0,  2'b01, 0, 2'd1, 8'd1, 0, 3'd1, 0);
        vecs[22] = mk(0, 2'b11, 2'b01, 0,  2'b00, 1, 2'd2, 8'd1, 0, 3'd1, 0);
        vecs[23] = mk(0, 2'b11, 2'b01, 0,  2'b00, 0, 2'd2, 8'd1, 0, 3'd1, 0);
        vecs[24] = mk(0, 2'b11, 2'b01, 0,  2'b00, 0, 2'd0, 8'd1, 0, 3'd1, 0);
        vecs[25] = mk(0, 2'b11, 2'b11, 0,  2'b00, 0, 2'd0, 8'd1, 0, 3'd1, 0);
        vecs[26] = mk(1, 2'b10, 2'b11, 0,  2'b10, 0, 2'd1, 8'd2, 0, 3'd2, 0);
        vecs[27] = mk(1, 2'b10, 2'b00, 0,  2'b00, 1, 2'd1, 8'd2, 0, 3'd2, 0);
        vecs[28] = mk(1, 2'b10, 2'b00, 0,  2'b00, 0, 2'd1, 8'd2, 0, 3'd2, 0);
        vecs[29] = mk(0, 2'b10, 2'b00, 0,  2'b00, 0, 2'd0, 8'd2, 0, 3'd2, 0);

        rst_n = 1'b0; act_en = 1'b0; lane_mask = 2'b00; req = 2'b00; cnt_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        compareField("rst_ack",   32'(ack),     32'd0);
        compareField("rst_done",  32'(done),    32'd0);
        compareField("rst_busy",  32'(busy),    32'd0);
        compareField("rst_state", 32'(state),   32'd0);
        compareField("rst_cnt",   32'(acc_cnt), 32'd0);
        compareField("rst_ovf",   32'(cnt_ovf), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 30; i++) begin
            applyStimulus(vecs[i]);
            @(posedge clk);
            #1;
            checkOutput();
        end

        // Reset one cycle after an accept must kill the pending done.
        @(negedge clk);
        act_en = 1'b1; lane_mask = 2'b11; req = 2'b01;
        @(posedge clk);
        #1;
        compareField("pre_rst_ack", 32'(ack), 32'd1);
        @(negedge clk);
        req   = 2'b00;
        rst_n = 1'b0;
        #1;
        compareField("async_rst_ack",   32'(ack),     32'd0);
        compareField("async_rst_done",  32'(done),    32'd0);
        compareField("async_rst_busy",  32'(busy),    32'd0);
        compareField("async_rst_state", 32'(state),   32'd0);
        compareField("async_rst_cnt",   32'(acc_cnt), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            compareField("post_rst_done", 32'(done), 32'd0);
            compareField("post_rst_ack",  32'(ack),  32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
        $finish;
    end

endmodule
